// File: rtl/mem_responder_if.sv
// Request/response bundle between the interconnect (master) and the memory responder (slave).
interface mem_responder_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [DATA_W-1:0] rdata;
    logic              rdata_ack;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rdata, rdata_ack, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rdata, rdata_ack, resp_err
    );
endinterface

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accepts one packet, waits WAIT_CYCLES, then
// pulses rdata_ack with read data or an out-of-range error.
module mem_responder #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input logic            clk,
    input logic            reset,
    mem_responder_if.slave bus
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    state_e            state_q;
    logic [3:0]        cnt_q;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              ack_q;
    logic              err_q;
    logic              ready_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    // With zero wait states the response is formed on the acceptance edge,
    // so it must come from the bus rather than from the latched packet.
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_in_range;
    logic [IDX_W-1:0]  sel_idx;
    logic [DATA_W-1:0] resp_data_d;

    always_comb begin
        sel_write = write_q;
        sel_addr  = addr_q;
        if (state_q == IDLE) begin
            sel_write = bus.req_write;
            sel_addr  = bus.req_addr;
        end
        sel_in_range = ({1'b0, sel_addr} < DEPTH_LIM);
        sel_idx      = IDX_W'(sel_addr);
        resp_data_d  = '0;
        if (!sel_write && sel_in_range) begin
            resp_data_d = mem_q[sel_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req_valid && ready_q) begin
                        write_q <= bus.req_write;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        cnt_q   <= 4'(WAIT_CYCLES);
                        ready_q <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= RESP;
                            ack_q   <= 1'b1;
                            err_q   <= !sel_in_range;
                            rdata_q <= resp_data_d;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= RESP;
                        ack_q   <= 1'b1;
                        err_q   <= !sel_in_range;
                        rdata_q <= resp_data_d;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    if (write_q && sel_in_range) begin
                        mem_q[sel_idx] <= wdata_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rdata     = rdata_q;
    assign bus.rdata_ack = ack_q;
    assign bus.resp_err  = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: dut_a (2 wait states, 200 words) and dut_b (zero wait, 256 words).
module tb_mem_responder;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    mem_responder_if #(.ADDR_W(8), .DATA_W(32)) ia ();
    mem_responder_if #(.ADDR_W(8), .DATA_W(32)) ib ();

    mem_responder #(
        .ADDR_W(8), .DATA_W(32), .DEPTH(200), .WAIT_CYCLES(2)
    ) dut_a (
        .clk(clk), .reset(reset), .bus(ia)
    );

    mem_responder #(
        .ADDR_W(8), .DATA_W(32), .DEPTH(256), .WAIT_CYCLES(0)
    ) dut_b (
        .clk(clk), .reset(reset), .bus(ib)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One complete dut_a transaction; ack is due three cycles after presentation.
    task automatic txn_a(input string tag, input logic wr, input logic [7:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
        ia.req_valid = 1'b1;
        ia.req_write = wr;
        ia.req_addr  = addr;
        ia.req_wdata = wd;
        tick();
        chk({tag, ".w1_ready"}, 32'(ia.req_ready), 32'd0);
        chk({tag, ".w1_ack"}, 32'(ia.rdata_ack), 32'd0);
        ia.req_valid = 1'b0;
        ia.req_write = 1'bx;
        ia.req_addr  = 'x;
        ia.req_wdata = 'x;
        tick();
        chk({tag, ".w2_ack"}, 32'(ia.rdata_ack), 32'd0);
        tick();
        chk({tag, ".ack"}, 32'(ia.rdata_ack), 32'd1);
        chk({tag, ".rdata"}, ia.rdata, exp_rd);
        chk({tag, ".err"}, 32'(ia.resp_err), 32'(exp_err));
        chk({tag, ".ack_ready"}, 32'(ia.req_ready), 32'd0);
        tick();
        chk({tag, ".idle_ready"}, 32'(ia.req_ready), 32'd1);
        chk({tag, ".idle_ack"}, 32'(ia.rdata_ack), 32'd0);
        chk({tag, ".idle_err"}, 32'(ia.resp_err), 32'd0);
        chk({tag, ".idle_rdata_hold"}, ia.rdata, exp_rd);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a valid write held on dut_a: reset must win.
        reset        = 1'b1;
        ia.req_valid = 1'b1;
        ia.req_write = 1'b1;
        ia.req_addr  = 8'h07;
        ia.req_wdata = 32'h0000_0077;
        ib.req_valid = 1'b0;
        ib.req_write = 1'b0;
        ib.req_addr  = '0;
        ib.req_wdata = '0;
        tick();
        tick();
        chk("rst.a_ready", 32'(ia.req_ready), 32'd1);
        chk("rst.a_rdata", ia.rdata, 32'd0);
        chk("rst.a_ack", 32'(ia.rdata_ack), 32'd0);
        chk("rst.a_err", 32'(ia.resp_err), 32'd0);
        chk("rst.b_ready", 32'(ib.req_ready), 32'd1);
        chk("rst.b_rdata", ib.rdata, 32'd0);
        chk("rst.b_ack", 32'(ib.rdata_ack), 32'd0);
        reset        = 1'b0;
        ia.req_valid = 1'b0;
        ia.req_write = 1'b0;
        ia.req_addr  = '0;
        ia.req_wdata = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle.a_ack", 32'(ia.rdata_ack), 32'd0);
            chk("idle.a_ready", 32'(ia.req_ready), 32'd1);
            chk("idle.b_ack", 32'(ib.rdata_ack), 32'd0);
        end

        txn_a("wr05", 1'b1, 8'h05, 32'hDEAD_BEEF, 32'd0, 1'b0);
        txn_a("rd05", 1'b0, 8'h05, 32'd0, 32'hDEAD_BEEF, 1'b0);
        txn_a("rd07_rst_won", 1'b0, 8'h07, 32'd0, 32'd0, 1'b0);

        txn_a("wrC8", 1'b1, 8'hC8, 32'h0000_1234, 32'd0, 1'b1);
        txn_a("rdC8", 1'b0, 8'hC8, 32'd0, 32'd0, 1'b1);
        txn_a("rdC7", 1'b0, 8'hC7, 32'd0, 32'd0, 1'b0);

        // Busy ignore: the write to 0x10 is held from the first WAIT cycle onward.
        ia.req_valid = 1'b1;
        ia.req_write = 1'b0;
        ia.req_addr  = 8'h10;
        tick();
        ia.req_write = 1'b1;
        ia.req_wdata = 32'h0000_AAAA;
        tick();
        chk("busy.wait_ack", 32'(ia.rdata_ack), 32'd0);
        chk("busy.wait_ready", 32'(ia.req_ready), 32'd0);
        tick();
        chk("busy.rd_ack", 32'(ia.rdata_ack), 32'd1);
        chk("busy.rd_rdata", ia.rdata, 32'd0);
        tick();
        chk("busy.idle_ready", 32'(ia.req_ready), 32'd1);
        chk("busy.idle_ack", 32'(ia.rdata_ack), 32'd0);
        tick();
        chk("busy.wr_accepted", 32'(ia.req_ready), 32'd0);
        ia.req_valid = 1'b0;
        tick();
        chk("busy.wr_wait_ack", 32'(ia.rdata_ack), 32'd0);
        tick();
        chk("busy.wr_ack", 32'(ia.rdata_ack), 32'd1);
        chk("busy.wr_rdata", ia.rdata, 32'd0);
        tick();
        txn_a("rd10", 1'b0, 8'h10, 32'd0, 32'h0000_AAAA, 1'b0);

        // Zero wait states with a continuously valid read of address 0.
        ib.req_valid = 1'b1;
        ib.req_write = 1'b0;
        ib.req_addr  = 8'h00;
        for (int i = 1; i <= 8; i++) begin
            logic odd;
            odd = (i % 2 == 1);
            tick();
            chk("zw.ack", 32'(ib.rdata_ack), 32'(odd));
            chk("zw.ready", 32'(ib.req_ready), 32'(!odd));
            chk("zw.rdata", ib.rdata, 32'd0);
        end
        ib.req_write = 1'b1;
        ib.req_addr  = 8'h33;
        ib.req_wdata = 32'hCAFE_0001;
        tick();
        chk("zw.wr_ack", 32'(ib.rdata_ack), 32'd1);
        chk("zw.wr_rdata", ib.rdata, 32'd0);
        ib.req_write = 1'b0;
        tick();
        chk("zw.gap_ready", 32'(ib.req_ready), 32'd1);
        tick();
        chk("zw.rd_ack", 32'(ib.rdata_ack), 32'd1);
        chk("zw.rd_rdata", ib.rdata, 32'hCAFE_0001);
        chk("zw.rd_err", 32'(ib.resp_err), 32'd0);
        ib.req_valid = 1'b0;
        tick();
        chk("zw.end_ack", 32'(ib.rdata_ack), 32'd0);

        // Reset during WAIT drops the write to 0x20 and clears storage.
        ia.req_valid = 1'b1;
        ia.req_write = 1'b1;
        ia.req_addr  = 8'h20;
        ia.req_wdata = 32'h0000_0055;
        tick();
        chk("midrst.accepted", 32'(ia.req_ready), 32'd0);
        ia.req_valid = 1'b0;
        reset        = 1'b1;
        tick();
        chk("midrst.ready", 32'(ia.req_ready), 32'd1);
        chk("midrst.ack", 32'(ia.rdata_ack), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("midrst.no_ack", 32'(ia.rdata_ack), 32'd0);
        end
        txn_a("rd20", 1'b0, 8'h20, 32'd0, 32'd0, 1'b0);
        txn_a("rd05_cleared", 1'b0, 8'h05, 32'd0, 32'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
